ysyx_25060170_mem_arbiter: RTL and testbench
============================================

# ysyx_25060170_mem_arbiter

Two-requester memory arbiter for the ysyx_25060170 core. It shares a single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It serialises one transaction at a time, captures the winner's request, drives the memory port and routes the response back to the owner. It sits between the IFU/LSU and the memory/bus interface.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; write mask width is DATA_W/8

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_rsp_valid  out  1  fetch data valid (single-cycle pulse)
- ifu_rsp_data  out  DATA_W  fetched instruction
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte write mask
- lsu_rsp_valid  out  1  load data / store ack (single-cycle pulse)
- lsu_rsp_data  out  DATA_W  load data; undefined for stores
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W, 1, DATA_W, DATA_W/8  registered request payload
- mem_rsp_valid  in  1  memory response (sent for both reads and writes)
- mem_rsp_data  in  DATA_W  read data

## Operation
- FSM states: IDLE, REQ, RSP. Registers: state, owner (IFU/LSU), last_owner, payload (addr, wen, wdata, wmask).
- IDLE: if any req_valid, pick the winner per the arbitration policy. Assert only the winner's req_ready combinationally in the same cycle. Capture the winner's payload and owner. Go to REQ. IFU captures force wen=0, wmask=0, wdata=0.
- REQ: mem_req_valid=1 with the registered payload. On mem_req_ready, go to RSP.
- RSP: mem_req_valid=0. On mem_rsp_valid, pass mem_rsp_data combinationally to the owner's rsp_data, pulse the owner's rsp_valid, set last_owner=owner, and go to IDLE.
- Both req_ready signals are 0 outside IDLE. At most one req_ready is high in any cycle. At most one transaction is outstanding.
- mem_rsp_valid in IDLE or REQ is ignored and dropped.
- rsp_valid to the non-owner is always 0. rsp_data of a non-owner is don't-care (it may mirror mem_rsp_data).
- Default policy is fixed priority: LSU wins on simultaneous requests.
- Requesters must accept a response in the cycle it is presented. There is no response backpressure.

## Timing
- Reset values: state=IDLE, owner=IFU, last_owner=IFU, payload=0. All outputs are 0: both req_ready are 0 only while rst is high; mem_req_valid=0, rsp_valid=0.
- Request accepted in cycle N (IDLE) → mem_req_valid high from cycle N+1.
- mem_req_ready seen in cycle M → RSP from M+1.
- mem_rsp_valid in cycle K ≥ M+1 → owner's rsp_valid in cycle K (zero-latency passthrough), IDLE at K+1.
- Best case with memory always ready and a 1-cycle response: accept N, response N+2, next accept N+3. Throughput is one transaction per 3 cycles.
- Payload is stable from REQ entry until the RSP exit. Requester inputs may change after their accept cycle.
- Reset mid-transaction (any state): return to IDLE next cycle, drop mem_req_valid, and discard any later response. No rsp_valid is issued for the aborted transaction.

## Configuration
- YSYX_25060170_ARB_RR_EN defined: round-robin arbitration. On simultaneous requests in IDLE, grant the requester that is not last_owner. After reset last_owner=IFU, so the first contention grants LSU. A single requester is always granted.
- Undefined: fixed LSU priority. last_owner is still maintained but does not affect arbitration.

## Test plan
- After reset, IFU-only request: ifu_addr=0x8000_0000, mem ready, 1-cycle rsp with data 0x0000_0413. Expect ifu_req_ready at cycle N, mem_addr=0x8000_0000/mem_wen=0 at N+1, ifu_rsp_valid with data 0x0000_0413 at N+2, lsu_rsp_valid never asserted.
- LSU store: addr 0x8000_1000, wdata 0xDEAD_BEEF, wmask 0xF, mem_req_ready held low 3 cycles. Expect the payload to stay stable through all REQ cycles, then a lsu_rsp_valid pulse after the memory response.
- Simultaneous IFU+LSU requests held for 4 transactions. Without the macro: LSU granted every time and IFU starves. With YSYX_25060170_ARB_RR_EN: grants alternate LSU, IFU, LSU, IFU.
- Spurious mem_rsp_valid in IDLE and in REQ. Expect no rsp_valid on either side and no state change.
- rst asserted for 1 cycle while in RSP. Expect IDLE next cycle, mem_req_valid=0, and a late mem_rsp_valid dropped. A fresh IFU fetch then completes normally.

Source files
------------

// File: rtl/ysyx_25060170_mem_arbiter_if.sv
// Bus bundle for the ysyx_25060170 memory arbiter.
// Carries the IFU request/response, LSU request/response and the shared
// memory port. The arbiter owns the memory port, so it takes the master
// view; the requesters and the memory together form the slave view.
interface ysyx_25060170_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // IFU side
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_W-1:0]     ifu_addr;
    logic                  ifu_rsp_valid;
    logic [DATA_W-1:0]     ifu_rsp_data;
    // LSU side
    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_W-1:0]     lsu_addr;
    logic                  lsu_wen;
    logic [DATA_W-1:0]     lsu_wdata;
    logic [DATA_W/8-1:0]   lsu_wmask;
    logic                  lsu_rsp_valid;
    logic [DATA_W-1:0]     lsu_rsp_data;
    // Memory side
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_wen;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_rsp_valid;
    logic [DATA_W-1:0]     mem_rsp_data;

    modport master (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport slave (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/ysyx_25060170_mem_arbiter.sv
// Two-requester memory arbiter: IFU (read-only) and LSU (read/write) share
// one memory port, one transaction at a time (IDLE -> REQ -> RSP).
// Optional feature: define YSYX_25060170_ARB_RR_EN for round-robin
// arbitration on contention; otherwise the LSU always wins.
module ysyx_25060170_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_25060170_mem_arbiter_if.master   bus
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;
    typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} owner_t;

    state_t              r_state;
    state_t              w_next_state;
    owner_t              r_owner;
    owner_t              r_last_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;

    logic                w_grant_ifu;
    logic                w_grant_lsu;
    logic                w_mem_req_valid;
    logic                w_ifu_rsp_valid;
    logic                w_lsu_rsp_valid;
    logic                w_rsp_fire;

    // Next-state, arbitration and handshake outputs; reset silences all of them
    always_comb begin
        w_next_state    = r_state;
        w_grant_ifu     = 1'b0;
        w_grant_lsu     = 1'b0;
        w_mem_req_valid = 1'b0;
        w_ifu_rsp_valid = 1'b0;
        w_lsu_rsp_valid = 1'b0;
        w_rsp_fire      = 1'b0;
        case (r_state)
            S_IDLE: begin
`ifdef YSYX_25060170_ARB_RR_EN
                if (bus.ifu_req_valid && bus.lsu_req_valid) begin
                    w_grant_lsu = (r_last_owner == OWN_IFU);
                    w_grant_ifu = (r_last_owner == OWN_LSU);
                end else begin
                    w_grant_lsu = bus.lsu_req_valid;
                    w_grant_ifu = bus.ifu_req_valid;
                end
`else
                w_grant_lsu = bus.lsu_req_valid;
                w_grant_ifu = bus.ifu_req_valid && !bus.lsu_req_valid;
`endif
                if (w_grant_ifu || w_grant_lsu) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                w_mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    w_next_state = S_RSP;
                end
            end
            S_RSP: begin
                if (bus.mem_rsp_valid) begin
                    w_rsp_fire      = 1'b1;
                    w_ifu_rsp_valid = (r_owner == OWN_IFU);
                    w_lsu_rsp_valid = (r_owner == OWN_LSU);
                    w_next_state    = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        if (rst) begin
            w_next_state    = S_IDLE;
            w_grant_ifu     = 1'b0;
            w_grant_lsu     = 1'b0;
            w_mem_req_valid = 1'b0;
            w_ifu_rsp_valid = 1'b0;
            w_lsu_rsp_valid = 1'b0;
            w_rsp_fire      = 1'b0;
        end
    end

    // State, owner and last-owner registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_IFU;
            r_last_owner <= OWN_IFU;
        end else begin
            r_state <= w_next_state;
            if (w_grant_lsu) begin
                r_owner <= OWN_LSU;
            end else if (w_grant_ifu) begin
                r_owner <= OWN_IFU;
            end
            if (w_rsp_fire) begin
                r_last_owner <= r_owner;
            end
        end
    end

    // Capture the winner's payload; it stays put until the next grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_grant_lsu) begin
            r_addr  <= bus.lsu_addr;
            r_wen   <= bus.lsu_wen;
            r_wdata <= bus.lsu_wdata;
            r_wmask <= bus.lsu_wmask;
        end else if (w_grant_ifu) begin
            r_addr  <= bus.ifu_addr;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end
    end

    assign bus.ifu_req_ready = w_grant_ifu;
    assign bus.lsu_req_ready = w_grant_lsu;
    assign bus.ifu_rsp_valid = w_ifu_rsp_valid;
    assign bus.lsu_rsp_valid = w_lsu_rsp_valid;
    assign bus.ifu_rsp_data  = bus.mem_rsp_data;
    assign bus.lsu_rsp_data  = bus.mem_rsp_data;
    assign bus.mem_req_valid = w_mem_req_valid;
    assign bus.mem_addr      = r_addr;
    assign bus.mem_wen       = r_wen;
    assign bus.mem_wdata     = r_wdata;
    assign bus.mem_wmask     = r_wmask;
endmodule

// File: tb/tb_ysyx_25060170_mem_arbiter.sv
// Testbench for ysyx_25060170_mem_arbiter: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// transaction-level model of the arbiter.
module tb_ysyx_25060170_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_25060170_mem_arbiter_if bus ();

    ysyx_25060170_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // stimulus for the next cycle
    logic        s_rst, s_iv, s_lv, s_lwen, s_mrr, s_mrv;
    logic [31:0] s_iaddr, s_laddr, s_lwdata, s_mrdata;
    logic [3:0]  s_lwmask;

    // transaction-level model: at most one outstanding transaction
    bit          m_busy, m_issued, m_owner_lsu, m_last_lsu;
    logic [31:0] m_addr, m_wdata;
    logic        m_wen;
    logic [3:0]  m_wmask;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic idle_stim();
        s_rst = 0; s_iv = 0; s_lv = 0; s_lwen = 0; s_mrr = 0; s_mrv = 0;
        s_iaddr = 0; s_laddr = 0; s_lwdata = 0; s_mrdata = 0; s_lwmask = 0;
    endtask

    // Apply stimulus at negedge, check outputs against the model, then
    // advance the model across the coming posedge.
    task automatic cycle();
        bit g_ifu, g_lsu, e_mv, e_irv, e_lrv;
        @(negedge clk);
        rst                = s_rst;
        bus.ifu_req_valid  = s_iv;
        bus.ifu_addr       = s_iaddr;
        bus.lsu_req_valid  = s_lv;
        bus.lsu_addr       = s_laddr;
        bus.lsu_wen        = s_lwen;
        bus.lsu_wdata      = s_lwdata;
        bus.lsu_wmask      = s_lwmask;
        bus.mem_req_ready  = s_mrr;
        bus.mem_rsp_valid  = s_mrv;
        bus.mem_rsp_data   = s_mrdata;
        #1;
        g_ifu = 0; g_lsu = 0; e_mv = 0; e_irv = 0; e_lrv = 0;
        if (s_rst) begin
            // everything quiet
        end else if (!m_busy) begin
            if (s_iv && s_lv) begin
`ifdef YSYX_25060170_ARB_RR_EN
                g_lsu = !m_last_lsu;
`else
                g_lsu = 1;
`endif
                g_ifu = !g_lsu;
            end else begin
                g_lsu = s_lv;
                g_ifu = s_iv;
            end
        end else if (!m_issued) begin
            e_mv = 1;
        end else if (s_mrv) begin
            e_lrv = m_owner_lsu;
            e_irv = !m_owner_lsu;
        end
        chk("ifu_req_ready", bus.ifu_req_ready, g_ifu);
        chk("lsu_req_ready", bus.lsu_req_ready, g_lsu);
        chk("mem_req_valid", bus.mem_req_valid, e_mv);
        chk("ifu_rsp_valid", bus.ifu_rsp_valid, e_irv);
        chk("lsu_rsp_valid", bus.lsu_rsp_valid, e_lrv);
        if (e_mv) begin
            chk("mem_addr",  bus.mem_addr,  m_addr);
            chk("mem_wen",   bus.mem_wen,   m_wen);
            chk("mem_wdata", bus.mem_wdata, m_wdata);
            chk("mem_wmask", bus.mem_wmask, m_wmask);
        end
        if (e_irv) chk("ifu_rsp_data", bus.ifu_rsp_data, s_mrdata);
        if (e_lrv) chk("lsu_rsp_data", bus.lsu_rsp_data, s_mrdata);
        if (s_rst) begin
            m_busy = 0; m_issued = 0; m_owner_lsu = 0; m_last_lsu = 0;
            m_addr = 0; m_wen = 0; m_wdata = 0; m_wmask = 0;
        end else if (g_lsu) begin
            m_busy = 1; m_issued = 0; m_owner_lsu = 1;
            m_addr = s_laddr; m_wen = s_lwen; m_wdata = s_lwdata; m_wmask = s_lwmask;
        end else if (g_ifu) begin
            m_busy = 1; m_issued = 0; m_owner_lsu = 0;
            m_addr = s_iaddr; m_wen = 0; m_wdata = 0; m_wmask = 0;
        end else if (m_busy && !m_issued) begin
            if (s_mrr) m_issued = 1;
        end else if (m_busy && s_mrv) begin
            m_busy = 0; m_last_lsu = m_owner_lsu;
        end
        cyc++;
    endtask

    task automatic do_reset();
        idle_stim();
        s_rst = 1; s_iv = 1; s_lv = 1;
        cycle();
        chk("rst_ifu_ready_low", bus.ifu_req_ready, 1'b0);
        chk("rst_lsu_ready_low", bus.lsu_req_ready, 1'b0);
        cycle();
        idle_stim();
    endtask

    bit exp_lsu [4];

    initial begin
        idle_stim();
        rst = 1;
        m_busy = 0; m_issued = 0; m_owner_lsu = 0; m_last_lsu = 0;
        m_addr = 0; m_wen = 0; m_wdata = 0; m_wmask = 0;

        // reset state
        do_reset();
        cycle();
        chk("reset_mem_addr", bus.mem_addr, 32'h0);
        chk("reset_mem_wen", bus.mem_wen, 1'b0);
        chk("reset_mem_valid", bus.mem_req_valid, 1'b0);

        // IFU-only fetch, memory ready, 1-cycle response
        s_iv = 1; s_iaddr = 32'h8000_0000; s_mrr = 1;
        cycle();
        chk("fetch_ifu_ready", bus.ifu_req_ready, 1'b1);
        s_iv = 0; s_iaddr = 32'h1234_5678;
        cycle();
        chk("fetch_mem_addr", bus.mem_addr, 32'h8000_0000);
        chk("fetch_mem_wen", bus.mem_wen, 1'b0);
        s_mrr = 0; s_mrv = 1; s_mrdata = 32'h0000_0413;
        cycle();
        chk("fetch_rsp_valid", bus.ifu_rsp_valid, 1'b1);
        chk("fetch_rsp_data", bus.ifu_rsp_data, 32'h0000_0413);
        chk("fetch_lsu_quiet", bus.lsu_rsp_valid, 1'b0);
        idle_stim();

        // LSU store with memory stalling 3 cycles
        s_lv = 1; s_laddr = 32'h8000_1000; s_lwen = 1; s_lwdata = 32'hDEAD_BEEF; s_lwmask = 4'hF;
        cycle();
        chk("store_lsu_ready", bus.lsu_req_ready, 1'b1);
        s_lv = 0; s_laddr = 32'h0; s_lwen = 0; s_lwdata = 32'h5555_AAAA; s_lwmask = 4'h1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("store_hold_addr", bus.mem_addr, 32'h8000_1000);
            chk("store_hold_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            chk("store_hold_wmask", bus.mem_wmask, 4'hF);
            chk("store_hold_wen", bus.mem_wen, 1'b1);
        end
        s_mrr = 1;
        cycle();
        s_mrr = 0;
        cycle();
        chk("store_no_early_rsp", bus.lsu_rsp_valid, 1'b0);
        s_mrv = 1; s_mrdata = 32'hCAFE_0001;
        cycle();
        chk("store_ack", bus.lsu_rsp_valid, 1'b1);
        idle_stim();

        // contention for 4 transactions from a fresh reset
`ifdef YSYX_25060170_ARB_RR_EN
        exp_lsu = '{1, 0, 1, 0};
`else
        exp_lsu = '{1, 1, 1, 1};
`endif
        do_reset();
        for (int t = 0; t < 4; t++) begin
            s_iv = 1; s_lv = 1; s_iaddr = 32'h8000_0100 + t * 4; s_laddr = 32'h8000_2000 + t * 4;
            s_mrr = 1; s_mrv = 0;
            cycle();
            chk("contend_lsu_ready", bus.lsu_req_ready, exp_lsu[t]);
            chk("contend_ifu_ready", bus.ifu_req_ready, !exp_lsu[t]);
            cycle();
            s_mrv = 1; s_mrdata = 32'h100 + t;
            cycle();
            chk("contend_rsp_owner", bus.lsu_rsp_valid, exp_lsu[t]);
        end
        idle_stim();

        // spurious responses in IDLE and in REQ
        s_mrv = 1; s_mrdata = 32'hBAD0_0000;
        cycle();
        chk("spur_idle_ifu", bus.ifu_rsp_valid, 1'b0);
        chk("spur_idle_lsu", bus.lsu_rsp_valid, 1'b0);
        s_mrv = 0; s_iv = 1; s_iaddr = 32'h8000_0040;
        cycle();
        chk("spur_still_idle", bus.ifu_req_ready, 1'b1);
        s_iv = 0; s_mrv = 1;
        cycle();
        chk("spur_req_ifu", bus.ifu_rsp_valid, 1'b0);
        chk("spur_req_valid", bus.mem_req_valid, 1'b1);
        s_mrv = 0; s_mrr = 1;
        cycle();
        chk("spur_req_kept", bus.mem_req_valid, 1'b1);
        s_mrr = 0; s_mrv = 1; s_mrdata = 32'h0000_0013;
        cycle();
        chk("spur_then_rsp", bus.ifu_rsp_valid, 1'b1);
        idle_stim();

        // reset while in RSP, late response dropped, fresh fetch completes
        s_iv = 1; s_iaddr = 32'h8000_0004; s_mrr = 1;
        cycle();
        s_iv = 0;
        cycle();
        s_mrr = 0; s_rst = 1;
        cycle();
        chk("abort_no_rsp", bus.ifu_rsp_valid, 1'b0);
        s_rst = 0; s_mrv = 1; s_mrdata = 32'hDEAD_0000;
        cycle();
        chk("late_rsp_ifu", bus.ifu_rsp_valid, 1'b0);
        chk("late_rsp_lsu", bus.lsu_rsp_valid, 1'b0);
        chk("late_mem_valid", bus.mem_req_valid, 1'b0);
        s_mrv = 0; s_iv = 1; s_iaddr = 32'h8000_0008;
        cycle();
        chk("refetch_ready", bus.ifu_req_ready, 1'b1);
        s_iv = 0; s_mrr = 1;
        cycle();
        chk("refetch_addr", bus.mem_addr, 32'h8000_0008);
        s_mrr = 0; s_mrv = 1; s_mrdata = 32'h0010_0073;
        cycle();
        chk("refetch_rsp", bus.ifu_rsp_valid, 1'b1);
        chk("refetch_data", bus.ifu_rsp_data, 32'h0010_0073);
        idle_stim();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s_rst    = ($urandom_range(0, 199) == 0);
            s_iv     = $urandom_range(0, 1);
            s_lv     = $urandom_range(0, 1);
            s_iaddr  = $urandom;
            s_laddr  = $urandom;
            s_lwen   = $urandom_range(0, 1);
            s_lwdata = $urandom;
            s_lwmask = 4'($urandom_range(0, 15));
            s_mrr    = $urandom_range(0, 1);
            s_mrv    = ($urandom_range(0, 2) == 0);
            s_mrdata = $urandom;
            cycle();
        end
        idle_stim();
        cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
